// File: rtl/dt_pkg.sv
// Shared types and helpers for the seven-segment display time-sharing logic.
package dt_pkg;
  localparam int DT_DIGITS  = 4;
  localparam int DT_DIGIT_W = 4;

  typedef enum logic {IDLE, OWN} dt_arb_state_t;

  function automatic logic [DT_DIGITS*DT_DIGIT_W-1:0] dt_pack(
    input logic [DT_DIGIT_W-1:0] n4,
    input logic [DT_DIGIT_W-1:0] n3,
    input logic [DT_DIGIT_W-1:0] n2,
    input logic [DT_DIGIT_W-1:0] n1
  );
    return {n4, n3, n2, n1};
  endfunction
endpackage

// File: rtl/dt_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last+1, optionally skipping last itself.
module rr_pick
  import dt_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          excl_en,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] w_cand;
  int            w_sum;

  always_comb begin
    found  = 1'b0;
    idx    = last;
    w_cand = '0;
    w_sum  = 0;
    // k == N wraps back onto last, which excl_en removes from the search
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(last) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = IW'(w_sum);
      if (!found && req[w_cand] && !(excl_en && (k == N))) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end
endmodule

// File: rtl/dt_arbiter.sv
// Round-robin display arbiter with a minimum hold time; drives num1..num4 of dt_module.
module dt_arbiter
  import dt_pkg::*;
#(
  parameter int          N_REQ       = 3,
  parameter int          HOLD_CYCLES = 48_000_000,
  parameter logic [15:0] IDLE_NUM    = 16'h0000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*16-1:0]        num_in,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [DT_DIGIT_W-1:0]      num1,
  output logic [DT_DIGIT_W-1:0]      num2,
  output logic [DT_DIGIT_W-1:0]      num3,
  output logic [DT_DIGIT_W-1:0]      num4
);
  localparam int            IW       = $clog2(N_REQ);
  localparam int            HW       = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  dt_arb_state_t r_state, w_state_nxt;
  logic [IW-1:0]    r_owner, r_ptr, w_idx;
  logic [N_REQ-1:0] r_grant;
  logic [HW-1:0]    r_hold_cnt;
  logic [15:0]      r_nums;
  logic             w_found, w_hold_done, w_load;
  logic [15:0]      w_num_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_num
    assign w_num_arr[g] = num_in[16*g +: 16];
  end

  assign w_hold_done = (r_hold_cnt == HOLD_MAX);

  // In OWN the pointer equals the owner, so excluding it rotates away from the owner
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req),
    .last    (r_ptr),
    .excl_en (r_state == OWN),
    .found   (w_found),
    .idx     (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_state_nxt = OWN;
        w_load      = 1'b1;
      end
      OWN: if (w_hold_done) begin
        if (w_found)             w_load      = 1'b1;
        else if (!req[r_owner])  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= IW'(N_REQ - 1);
      r_grant    <= '0;
      r_hold_cnt <= '0;
      r_nums     <= IDLE_NUM;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_owner    <= w_idx;
        r_ptr      <= w_idx;
        r_grant    <= N_REQ'(1) << w_idx;
        r_hold_cnt <= '0;
      end else begin
        if (w_state_nxt == IDLE) r_grant <= '0;
        if ((r_state == OWN) && !w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      // Nums trail grant by one stage and freeze while the owner is not requesting
      if (r_state == IDLE)   r_nums <= IDLE_NUM;
      else if (req[r_owner]) r_nums <= w_num_arr[r_owner];
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = (r_state == OWN);
  assign num1  = r_nums[3:0];
  assign num2  = r_nums[7:4];
  assign num3  = r_nums[11:8];
  assign num4  = r_nums[15:12];
endmodule

// File: tb/tb_dt_arbiter.sv
// Scoreboard bench for dt_arbiter: per-cycle directed vectors with hand-derived expectations.
module tb_dt_arbiter;
  import dt_pkg::*;

  localparam int N = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*16-1:0] num_in;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic           busy;
  logic [3:0]     num1, num2, num3, num4;

  typedef struct {
    logic [N-1:0] grant;
    logic [15:0]  nums;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  dt_arbiter #(.N_REQ(N), .HOLD_CYCLES(4), .IDLE_NUM(16'hEEEE)) dut (
    .CLK(CLK), .RST(RST), .req(req), .num_in(num_in),
    .grant(grant), .owner(owner), .busy(busy),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge
  task automatic cyc(input string nm, input logic r, input logic [N-1:0] rq,
                     input logic [N-1:0] eg, input logic [15:0] en);
    exp_t e;
    RST = r;
    req = rq;
    e.grant = eg;
    e.nums  = en;
    e.name  = nm;
    sb_q.push_back(e);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [1:0]  eo;
      logic [15:0] got;
      e  = sb_q.pop_front();
      eo = 2'd0;
      for (int i = 0; i < N; i++) if (e.grant[i]) eo = 2'(i);
      got = dt_pack(num4, num3, num2, num1);
      n_chk++;
      if (grant !== e.grant || busy !== (|e.grant) || got !== e.nums ||
          ((|e.grant) && owner !== eo)) begin
        n_fail++;
        $display("FAIL %s @%0t: got grant=%b busy=%b owner=%0d nums=%h, want grant=%b busy=%b owner=%0d nums=%h",
                 e.name, $time, grant, busy, owner, got, e.grant, |e.grant, eo, e.nums);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RST    = 1'b1;
    req    = '0;
    num_in = {16'h2222, 16'h1111, 16'h0000};

    cyc("reset0", 1, 3'b111, 3'b000, 16'hEEEE);
    cyc("reset1", 1, 3'b111, 3'b000, 16'hEEEE);

    // rotation with all three requesting
    cyc("rot_g0", 0, 3'b111, 3'b001, 16'hEEEE);
    for (int i = 0; i < 3; i++) cyc("rot_o0", 0, 3'b111, 3'b001, 16'h0000);
    cyc("rot_g1", 0, 3'b111, 3'b010, 16'h0000);
    for (int i = 0; i < 3; i++) cyc("rot_o1", 0, 3'b111, 3'b010, 16'h1111);
    cyc("rot_g2", 0, 3'b111, 3'b100, 16'h1111);
    for (int i = 0; i < 3; i++) cyc("rot_o2", 0, 3'b111, 3'b100, 16'h2222);
    cyc("rot_wrap", 0, 3'b111, 3'b001, 16'h2222);
    // all drop: owner 0 keeps its hold with frozen nums, then IDLE
    for (int i = 0; i < 3; i++) cyc("freeze", 0, 3'b000, 3'b001, 16'h2222);
    cyc("rel_idle", 0, 3'b000, 3'b000, 16'h2222);
    cyc("idle_num", 0, 3'b000, 3'b000, 16'hEEEE);

    // early drop
    num_in[15:0] = 16'h1234;
    cyc("drop_g", 0, 3'b001, 3'b001, 16'hEEEE);
    cyc("drop_l", 0, 3'b001, 3'b001, 16'h1234);
    cyc("drop_h2", 0, 3'b000, 3'b001, 16'h1234);
    cyc("drop_h3", 0, 3'b000, 3'b001, 16'h1234);
    cyc("drop_rel", 0, 3'b000, 3'b000, 16'h1234);
    cyc("drop_idle", 0, 3'b000, 3'b000, 16'hEEEE);

    // sole requester with live value changes, retained past hold
    for (int k = 1; k <= 20; k++) begin
      num_in[31:16] = 16'h1000 + 16'(k);
      cyc("sole", 0, 3'b010, 3'b010, (k == 1) ? 16'hEEEE : 16'h1000 + 16'(k));
    end
    cyc("sole_rel", 0, 3'b000, 3'b000, 16'h1014);
    cyc("sole_idle", 0, 3'b000, 3'b000, 16'hEEEE);

    // late arrival of requester 2 while owner 0 is mid-hold; requester 1 skipped
    num_in = {16'h2222, 16'h1111, 16'h0000};
    cyc("late_g0", 0, 3'b001, 3'b001, 16'hEEEE);
    cyc("late_h1", 0, 3'b001, 3'b001, 16'h0000);
    cyc("late_h2", 0, 3'b101, 3'b001, 16'h0000);
    cyc("late_h3", 0, 3'b101, 3'b001, 16'h0000);
    cyc("late_g2", 0, 3'b101, 3'b100, 16'h0000);
    cyc("late_o2", 0, 3'b101, 3'b100, 16'h2222);

    // reset while owned by 2, then requester 0 first
    cyc("mrst", 1, 3'b101, 3'b000, 16'hEEEE);
    cyc("mrst_g0", 0, 3'b101, 3'b001, 16'hEEEE);
    cyc("mrst_o0", 0, 3'b101, 3'b001, 16'h0000);
    // reset while owned by 0: pointer must return to priority on requester 0
    cyc("mrst2", 1, 3'b111, 3'b000, 16'hEEEE);
    cyc("mrst2_g0", 0, 3'b111, 3'b001, 16'hEEEE);
    cyc("mrst2_o0", 0, 3'b111, 3'b001, 16'h0000);

    @(negedge CLK);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
